fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register. Owns the PC, fetches
//  16-bit instructions over a request/done memory handshake, and presents
//  instr / PC+2 / valid to the decode stage. if_id_valid drives the decoder's
//  Valid_PC input. Honours decode stalls, taken-branch/jump redirects, and
//  HALT from the decoder.
// PARAMETERS
//  PC_W      16       PC and memory address width
//  RESET_PC  16'h0000 PC value after reset
//  NOP_INSTR 16'h0800 instruction word placed in IF/ID when invalid (opcode 00001)
// PORTS
//  clk            in   1     clock; all state updates on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  imem_rd        out  1     fetch request; held with imem_addr until imem_done
//  imem_addr      out  PC_W  fetch address, registered (req_addr)
//  imem_rdata     in   16    instruction data, valid when imem_done=1
//  imem_done      in   1     1-cycle completion pulse for the outstanding request
//  stall_id       in   1     decode hazard; IF/ID must hold its contents
//  flush          in   1     taken branch/jump; squash IF/ID, refetch redirect_pc
//  redirect_pc    in   PC_W  new PC, sampled when flush=1
//  halt_id        in   1     decoder Halt output for the instruction in IF/ID
//  if_id_instr    out  16    instruction to decode
//  if_id_pc2      out  PC_W  PC+2 of if_id_instr
//  if_id_valid    out  1     if_id_instr is a real instruction
//  halted         out  1     fetch permanently stopped
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, req_addr=RESET_PC, state=IDLE, imem_rd=0,
//   if_id_instr=NOP_INSTR, if_id_pc2=0, if_id_valid=0, buf_valid=0, halted=0.
//  Handshake: imem_rd/imem_addr are stable from request issue until the cycle
//   imem_done=1; at most one request outstanding; imem_rd may be withdrawn only
//   in the cycle after done. imem_done with imem_rd=0 is ignored.
//  States:
//   IDLE    1 cycle after reset release -> REQ (req_addr=pc, imem_rd=1).
//   REQ     waiting. On done: if !stall_id -> rdata loads IF/ID (valid=1,
//           pc2=pc+2), pc+=2, next request issued back-to-back (stays REQ);
//           if stall_id -> rdata into 1-entry skid buffer, pc+=2, -> FULL.
//   FULL    imem_rd=0, IF/ID holds. When stall_id=0: buffer -> IF/ID,
//           buf_valid=0, new request at pc -> REQ.
//   DISCARD flushed/halted while request outstanding; keep imem_rd=1 on old
//           req_addr; on done drop data -> REQ at pc (or HALT if halt_pend).
//   HALT    imem_rd=0, halted=1, if_id_valid=0; left only by reset.
//  Flush (highest priority, any state except HALT): pc<=redirect_pc,
//   if_id_valid<=0, if_id_instr<=NOP_INSTR, buf_valid<=0, halt_pend<=0.
//   Outstanding request not completing this cycle -> DISCARD; completing this
//   cycle or none outstanding -> REQ at redirect_pc next cycle. Data returned
//   the flush cycle is dropped. Flush beats stall_id and halt_id.
//  Halt: accepted when halt_id & if_id_valid & !stall_id & !flush. IF/ID
//   invalidated, buffer cleared; outstanding request -> DISCARD with
//   halt_pend=1, else -> HALT next cycle.
//  stall_id without done: IF/ID, pc, buffer unchanged; a request keeps pending.
//  Arithmetic: pc+2 modulo 2^PC_W (16'hFFFE -> 16'h0000); no alignment check.
//  Reset mid-request: all state cleared immediately; a later imem_done is
//   ignored because imem_rd=0 until IDLE->REQ.
// TESTING
//  Reset, done 1 cycle after each req, no stall -> addrs 0000,0002,0004;
//   IF/ID gets each word one cycle after done, valid=1, pc2=addr+2.
//  stall_id=1 across a done with rdata=16'h4123 -> IF/ID unchanged, FULL,
//   imem_rd=0; stall drop -> IF/ID=4123, next req at 0006.
//  flush redirect_pc=0040 while req to 0008 pending 3 cycles -> DISCARD,
//   0008 data dropped, next imem_addr=0040, no bad valid.
//  halt_id with valid IF/ID, no outstanding req -> halted=1 next cycle,
//   imem_rd stays 0, if_id_valid=0 for 20 cycles; flush ignored.
//  pc=FFFE fetch -> if_id_pc2=0000, next imem_addr=0000.
//  rst_n low mid-request -> outputs to reset values same cycle, fetch restarts
//   at RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/done bus between the fetch stage (master) and
// the instruction memory (slave).
interface fetch_stage_if #(
  parameter int PC_W = 16
);
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_done;

  modport master (output imem_rd, imem_addr, input imem_rdata, imem_done);
  modport slave  (input imem_rd, imem_addr, output imem_rdata, imem_done);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, fetches
// over a request/done handshake, and handles stall, flush and halt.
module fetch_stage #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = 16'h0800
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_stage_if.master     imem,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_id,
  output logic [15:0]       if_id_instr,
  output logic [PC_W-1:0]   if_id_pc2,
  output logic              if_id_valid,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_FULL, S_DISCARD, S_HALT
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q, req_addr_q, pc2_q, buf_pc2_q;
  logic [15:0]     instr_q, buf_q;
  logic            rd_q, valid_q, buf_valid_q, halt_pend_q, halted_q;

  logic            done;
  logic            halt_ok;
  logic [PC_W-1:0] pc_plus2;

  // A done pulse only counts while our request is actually on the bus.
  assign done     = imem.imem_done & rd_q;
  assign halt_ok  = halt_id & valid_q & ~stall_id & ~flush;
  assign pc_plus2 = pc_q + PC_W'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      rd_q        <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc2_q       <= '0;
      valid_q     <= 1'b0;
      buf_q       <= '0;
      buf_pc2_q   <= '0;
      buf_valid_q <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else if (state_q == S_HALT) begin
      rd_q     <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b1;
    end else if (flush) begin
      pc_q        <= redirect_pc;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      halt_pend_q <= 1'b0;
      if (rd_q && !imem.imem_done) begin
        state_q <= S_DISCARD;
      end else begin
        state_q    <= S_REQ;
        rd_q       <= 1'b1;
        req_addr_q <= redirect_pc;
      end
    end else if (halt_ok) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      if (rd_q && !imem.imem_done) begin
        state_q     <= S_DISCARD;
        halt_pend_q <= 1'b1;
      end else begin
        state_q  <= S_HALT;
        rd_q     <= 1'b0;
        halted_q <= 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_REQ;
          rd_q       <= 1'b1;
          req_addr_q <= pc_q;
        end
        S_REQ: begin
          if (done) begin
            pc_q <= pc_plus2;
            if (!stall_id) begin
              instr_q    <= imem.imem_rdata;
              valid_q    <= 1'b1;
              pc2_q      <= pc_plus2;
              req_addr_q <= pc_plus2;
            end else begin
              buf_q       <= imem.imem_rdata;
              buf_pc2_q   <= pc_plus2;
              buf_valid_q <= 1'b1;
              rd_q        <= 1'b0;
              state_q     <= S_FULL;
            end
          end else if (!stall_id) begin
            // Decode consumed IF/ID with nothing new behind it: insert a bubble.
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
          end
        end
        S_FULL: begin
          if (!stall_id && buf_valid_q) begin
            instr_q     <= buf_q;
            pc2_q       <= buf_pc2_q;
            valid_q     <= 1'b1;
            buf_valid_q <= 1'b0;
            rd_q        <= 1'b1;
            req_addr_q  <= pc_q;
            state_q     <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (done) begin
            if (halt_pend_q) begin
              state_q     <= S_HALT;
              rd_q        <= 1'b0;
              halted_q    <= 1'b1;
              halt_pend_q <= 1'b0;
            end else begin
              state_q    <= S_REQ;
              req_addr_q <= pc_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_rd   = rd_q;
  assign imem.imem_addr = req_addr_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc2      = pc2_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, back-to-back fetch,
// stall skid, flush discard, halt, reset mid-request and PC wrap.
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        stall_id, flush, halt_id;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr, if_id_pc2;
  logic        if_id_valid, halted;

  int errors = 0;
  int checks = 0;

  fetch_stage_if #(.PC_W(16)) bus ();

  fetch_stage #(.PC_W(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus.master),
    .stall_id    (stall_id),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt_id     (halt_id),
    .if_id_instr (if_id_instr),
    .if_id_pc2   (if_id_pc2),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", bus.imem_rd); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", bus.imem_addr); end
    checks++; if (if_id_instr !== 16'h0800) begin errors++; $display("FAIL reset_instr got=%h exp=0800", if_id_instr); end
    checks++; if (if_id_pc2 !== 16'h0000) begin errors++; $display("FAIL reset_pc2 got=%h exp=0000", if_id_pc2); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL fetch_req0 rd=%b addr=%h exp rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
    step();
    bus.imem_done = 1'b1; bus.imem_rdata = 16'hA001;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_instr !== 16'hA001 || if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0002) begin errors++; $display("FAIL fetch_w0 instr=%h v=%b pc2=%h exp A001 1 0002", if_id_instr, if_id_valid, if_id_pc2); end
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL fetch_req1 rd=%b addr=%h exp rd=1 addr=0002", bus.imem_rd, bus.imem_addr); end
    step();
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0800) begin errors++; $display("FAIL fetch_bubble v=%b instr=%h exp 0 0800", if_id_valid, if_id_instr); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'hA002;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_instr !== 16'hA002 || if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0004) begin errors++; $display("FAIL fetch_w1 instr=%h v=%b pc2=%h exp A002 1 0004", if_id_instr, if_id_valid, if_id_pc2); end
    checks++; if (bus.imem_addr !== 16'h0004) begin errors++; $display("FAIL fetch_req2 addr=%h exp 0004", bus.imem_addr); end
  endtask

  task automatic test_stall();
    stall_id = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'hA002) begin errors++; $display("FAIL stall_hold_pre v=%b instr=%h exp 1 A002", if_id_valid, if_id_instr); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'h4123;
    step();
    bus.imem_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL stall_full_rd got=%b exp=0", bus.imem_rd); end
    checks++; if (if_id_instr !== 16'hA002 || if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0004) begin errors++; $display("FAIL stall_full_ifid instr=%h v=%b pc2=%h exp A002 1 0004", if_id_instr, if_id_valid, if_id_pc2); end
    step();
    checks++; if (bus.imem_rd !== 1'b0 || if_id_instr !== 16'hA002) begin errors++; $display("FAIL stall_full_hold rd=%b instr=%h exp 0 A002", bus.imem_rd, if_id_instr); end
    stall_id = 1'b0;
    step();
    checks++; if (if_id_instr !== 16'h4123 || if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0006) begin errors++; $display("FAIL stall_release instr=%h v=%b pc2=%h exp 4123 1 0006", if_id_instr, if_id_valid, if_id_pc2); end
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_nextreq rd=%b addr=%h exp 1 0006", bus.imem_rd, bus.imem_addr); end
  endtask

  task automatic test_flush();
    bus.imem_done = 1'b1; bus.imem_rdata = 16'h1111;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_instr !== 16'h1111 || if_id_pc2 !== 16'h0008 || bus.imem_addr !== 16'h0008) begin errors++; $display("FAIL flush_pre instr=%h pc2=%h addr=%h exp 1111 0008 0008", if_id_instr, if_id_pc2, bus.imem_addr); end
    step();
    step();
    flush = 1'b1; redirect_pc = 16'h0040;
    step();
    flush = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0008) begin errors++; $display("FAIL flush_discard_hold rd=%b addr=%h exp 1 0008", bus.imem_rd, bus.imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0800) begin errors++; $display("FAIL flush_squash v=%b instr=%h exp 0 0800", if_id_valid, if_id_instr); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'hDEAD;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0800) begin errors++; $display("FAIL flush_drop v=%b instr=%h exp 0 0800", if_id_valid, if_id_instr); end
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL flush_redirect rd=%b addr=%h exp 1 0040", bus.imem_rd, bus.imem_addr); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'h2222;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_instr !== 16'h2222 || if_id_valid !== 1'b1 || if_id_pc2 !== 16'h0042) begin errors++; $display("FAIL flush_refetch instr=%h v=%b pc2=%h exp 2222 1 0042", if_id_instr, if_id_valid, if_id_pc2); end
  endtask

  task automatic test_halt();
    stall_id = 1'b1;
    bus.imem_done = 1'b1; bus.imem_rdata = 16'h3333;
    step();
    bus.imem_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b0 || if_id_instr !== 16'h2222) begin errors++; $display("FAIL halt_setup rd=%b instr=%h exp 0 2222", bus.imem_rd, if_id_instr); end
    stall_id = 1'b0; halt_id = 1'b1;
    step();
    halt_id = 1'b0;
    checks++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin errors++; $display("FAIL halt_enter halted=%b v=%b rd=%b exp 1 0 0", halted, if_id_valid, bus.imem_rd); end
    for (int i = 0; i < 20; i++) begin
      flush = (i == 5); redirect_pc = 16'h1234;
      bus.imem_done = (i == 10);
      step();
      checks++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin errors++; $display("FAIL halt_hold cyc=%0d halted=%b v=%b rd=%b exp 1 0 0", i, halted, if_id_valid, bus.imem_rd); end
    end
    flush = 1'b0; bus.imem_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL rst_restart0 rd=%b addr=%h halted=%b exp 1 0000 0", bus.imem_rd, bus.imem_addr, halted); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'h7777;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_instr !== 16'h7777 || bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL rst_prefetch instr=%h addr=%h exp 7777 0002", if_id_instr, bus.imem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_rd !== 1'b0 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_async_bus rd=%b addr=%h exp 0 0000", bus.imem_rd, bus.imem_addr); end
    checks++; if (if_id_instr !== 16'h0800 || if_id_pc2 !== 16'h0000 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_async_ifid instr=%h pc2=%h v=%b exp 0800 0000 0", if_id_instr, if_id_pc2, if_id_valid); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'hBEEF;
    step();
    bus.imem_done = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_restart1 rd=%b addr=%h v=%b exp 1 0000 0", bus.imem_rd, bus.imem_addr, if_id_valid); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; redirect_pc = 16'hFFFE;
    bus.imem_done = 1'b1; bus.imem_rdata = 16'hBAD0;
    step();
    flush = 1'b0; bus.imem_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'hFFFE || if_id_valid !== 1'b0) begin errors++; $display("FAIL wrap_redirect rd=%b addr=%h v=%b exp 1 FFFE 0", bus.imem_rd, bus.imem_addr, if_id_valid); end
    bus.imem_done = 1'b1; bus.imem_rdata = 16'h5555;
    step();
    bus.imem_done = 1'b0;
    checks++; if (if_id_instr !== 16'h5555 || if_id_pc2 !== 16'h0000 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc2 instr=%h pc2=%h v=%b exp 5555 0000 1", if_id_instr, if_id_pc2, if_id_valid); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got=%h exp 0000", bus.imem_addr); end
  endtask

  initial begin
    rst_n = 1'b0; stall_id = 1'b0; flush = 1'b0; halt_id = 1'b0;
    redirect_pc = 16'h0000;
    bus.imem_done = 1'b0; bus.imem_rdata = 16'h0000;
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
